// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the fetch/decode boundary.
package pipe_pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0000;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_entry_t;

endpackage

// File: rtl/if_queue_if.sv
// Fetch-side and decode-side handshake bundle of the instruction fetch queue.
// Handshake: an entry moves on a rising Clk edge when its valid and the
// receiver's ready are both high; fetch's ready is ~Stall, decode's is D_Ready.
interface if_queue_if #(
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic        F_Valid;
  logic [31:0] F_PC;
  logic [31:0] F_Inst;
  logic        Stall;
  logic        Flush;
  logic        D_Ready;
  logic        D_Valid;
  logic [31:0] D_PC;
  logic [31:0] D_Inst;
  logic [AW:0] Count;

  modport slave (
    input  F_Valid, F_PC, F_Inst, Flush, D_Ready,
    output Stall, D_Valid, D_PC, D_Inst, Count
  );

  modport master (
    output F_Valid, F_PC, F_Inst, Flush, D_Ready,
    input  Stall, D_Valid, D_PC, D_Inst, Count
  );

endinterface

// File: rtl/ifq_ram.sv
// DEPTH x 64 entry storage: one synchronous write port, one asynchronous read
// port, no reset (contents are hidden by the queue's output gating).
module ifq_ram
  import pipe_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  if_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output if_entry_t     rdata
);

  if_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_queue.sv
// Instruction fetch queue between PC/instruction memory and decode.
// Optional zero-latency empty bypass: define IFQ_BYPASS_EN.
module if_queue
  import pipe_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic      Clk,
  input logic      Clr,
  if_queue_if.slave q
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  if_entry_t     wentry;
  if_entry_t     head;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign wentry = '{pc: q.F_PC, inst: q.F_Inst};

  // Stall comes from the registered count only, so decode's ready never
  // reaches the PC register combinationally.
  assign q.Stall = full;
  assign q.Count = count;
  assign pop     = ~empty & q.D_Ready & ~q.Flush;

`ifdef IFQ_BYPASS_EN
  logic bypass;
  assign bypass = empty & q.F_Valid & ~q.Flush;
  // A bypassed instruction taken by decode in the same cycle is never stored.
  assign push   = q.F_Valid & ~full & ~q.Flush & ~(bypass & q.D_Ready);

  always_comb begin
    q.D_Valid = 1'b0;
    q.D_PC    = PC_RESET;
    q.D_Inst  = INST_NOP;
    if (!empty) begin
      q.D_Valid = 1'b1;
      q.D_PC    = head.pc;
      q.D_Inst  = head.inst;
    end else if (bypass) begin
      q.D_Valid = 1'b1;
      q.D_PC    = q.F_PC;
      q.D_Inst  = q.F_Inst;
    end
  end
`else
  assign push = q.F_Valid & ~full & ~q.Flush;

  always_comb begin
    q.D_Valid = 1'b0;
    q.D_PC    = PC_RESET;
    q.D_Inst  = INST_NOP;
    if (!empty) begin
      q.D_Valid = 1'b1;
      q.D_PC    = head.pc;
      q.D_Inst  = head.inst;
    end
  end
`endif

  ifq_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (Clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wentry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Flush outranks push and pop: everything in flight is discarded.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (q.Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_queue.sv
// Directed bench for if_queue (default build, no bypass): vector table plus
// hand-written wrap and asynchronous-reset sequences.
module tb_if_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic        fv;
    logic [31:0] pc;
    logic        fl;
    logic        dr;
    logic        ev;
    logic [31:0] epc;
    logic [2:0]  ecnt;
    logic        est;
  } vec_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[$];
  logic [31:0] exp_q[$];

  if_queue_if #(.DEPTH(DEPTH)) q ();

  if_queue #(.DEPTH(DEPTH)) dut (
    .Clk (clk),
    .Clr (clr),
    .q   (q)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic fv, input logic [31:0] pc, input logic fl, input logic dr,
                     input logic ev, input logic [31:0] epc, input logic [2:0] ecnt,
                     input logic est);
    vec_t v;
    v.fv = fv; v.pc = pc; v.fl = fl; v.dr = dr;
    v.ev = ev; v.epc = epc; v.ecnt = ecnt; v.est = est;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic fv, input logic [31:0] pc, input logic fl, input logic dr);
    q.F_Valid = fv;
    q.F_PC    = pc;
    q.F_Inst  = inst_of(pc);
    q.Flush   = fl;
    q.D_Ready = dr;
  endtask

  initial begin
    drive(1'b0, 32'h0, 1'b0, 1'b0);

    // fill to full; fifth fetch refused
    add(1, 32'h00, 0, 0,  1, 32'h00, 1, 0);
    add(1, 32'h04, 0, 0,  1, 32'h00, 2, 0);
    add(1, 32'h08, 0, 0,  1, 32'h00, 3, 0);
    add(1, 32'h0C, 0, 0,  1, 32'h00, 4, 1);
    add(1, 32'h10, 0, 0,  1, 32'h00, 4, 1);
    // drain from full
    add(0, 32'h00, 0, 1,  1, 32'h04, 3, 0);
    add(0, 32'h00, 0, 1,  1, 32'h08, 2, 0);
    add(0, 32'h00, 0, 1,  1, 32'h0C, 1, 0);
    add(0, 32'h00, 0, 1,  0, 32'h00, 0, 0);
    // streaming: count holds at 1
    add(1, 32'h100, 0, 1, 1, 32'h100, 1, 0);
    add(1, 32'h104, 0, 1, 1, 32'h104, 1, 0);
    add(1, 32'h108, 0, 1, 1, 32'h108, 1, 0);
    add(1, 32'h10C, 0, 1, 1, 32'h10C, 1, 0);
    add(0, 32'h000, 0, 1, 0, 32'h000, 0, 0);
    // flush at count 3 with push and pop requested
    add(1, 32'h20, 0, 0,  1, 32'h20, 1, 0);
    add(1, 32'h24, 0, 0,  1, 32'h20, 2, 0);
    add(1, 32'h28, 0, 0,  1, 32'h20, 3, 0);
    add(1, 32'h40, 1, 1,  0, 32'h00, 0, 0);
    add(0, 32'h00, 0, 1,  0, 32'h00, 0, 0);
    add(1, 32'h44, 0, 0,  1, 32'h44, 1, 0);
    add(0, 32'h00, 1, 0,  0, 32'h00, 0, 0);
    // full with pop: inbound refused, accepted next cycle
    add(1, 32'h50, 0, 0,  1, 32'h50, 1, 0);
    add(1, 32'h54, 0, 0,  1, 32'h50, 2, 0);
    add(1, 32'h58, 0, 0,  1, 32'h50, 3, 0);
    add(1, 32'h5C, 0, 0,  1, 32'h50, 4, 1);
    add(1, 32'h60, 0, 1,  1, 32'h54, 3, 0);
    add(1, 32'h60, 0, 1,  1, 32'h58, 3, 0);
    add(0, 32'h00, 0, 1,  1, 32'h5C, 2, 0);
    add(0, 32'h00, 0, 1,  1, 32'h60, 1, 0);
    add(0, 32'h00, 0, 1,  0, 32'h00, 0, 0);
    // ready on empty is a no-op
    add(0, 32'h00, 0, 1,  0, 32'h00, 0, 0);

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset d_valid", 32'(q.D_Valid), 32'h0);
    chk("reset d_pc",    q.D_PC,         32'h0);
    chk("reset d_inst",  q.D_Inst,       32'h0);
    chk("reset stall",   32'(q.Stall),   32'h0);
    chk("reset count",   32'(q.Count),   32'h0);
    clr = 1'b0;

    // table
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].fv, tbl[i].pc, tbl[i].fl, tbl[i].dr);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d d_valid", i), 32'(q.D_Valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d d_pc", i),    q.D_PC,         tbl[i].ev ? tbl[i].epc : 32'h0);
      chk($sformatf("vec%0d d_inst", i),  q.D_Inst,       tbl[i].ev ? inst_of(tbl[i].epc) : 32'h0);
      chk($sformatf("vec%0d count", i),   32'(q.Count),   32'(tbl[i].ecnt));
      chk($sformatf("vec%0d stall", i),   32'(q.Stall),   32'(tbl[i].est));
    end

    // nine entries with interleaved pops: pointers wrap twice
    begin
      int pushed = 0;
      int cyc = 0;
      while ((pushed < 9 || exp_q.size() > 0) && cyc < 100) begin
        logic        fv, dr, acc;
        logic [31:0] pc, exp_pc;
        @(negedge clk);
        fv = (pushed < 9);
        pc = 32'h200 + 32'(4 * pushed);
        dr = (cyc % 3) != 0;
        drive(fv, pc, 1'b0, dr);
        #1;
        chk($sformatf("wrap%0d count", cyc), 32'(q.Count), 32'(exp_q.size()));
        chk($sformatf("wrap%0d d_valid", cyc), 32'(q.D_Valid), 32'(exp_q.size() > 0));
        acc = fv && (exp_q.size() != DEPTH);
        if (dr && exp_q.size() > 0) begin
          exp_pc = exp_q.pop_front();
          chk($sformatf("wrap%0d d_pc", cyc), q.D_PC, exp_pc);
          chk($sformatf("wrap%0d d_inst", cyc), q.D_Inst, inst_of(exp_pc));
        end
        if (acc) begin
          exp_q.push_back(pc);
          pushed++;
        end
        cyc++;
      end
      if (pushed < 9 || exp_q.size() > 0) begin
        n_vec++;
        n_err++;
        $display("FAIL wrap timeout: pushed %0d left %0d, expected 9 and 0", pushed, exp_q.size());
      end
    end

    // asynchronous reset mid-cycle at count 2
    @(negedge clk);
    drive(1'b1, 32'h300, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h304, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("pre_clr count", 32'(q.Count), 32'h2);
    chk("pre_clr d_pc",  q.D_PC,       32'h300);
    #2;
    clr = 1'b1;
    #1;
    chk("async_clr d_valid", 32'(q.D_Valid), 32'h0);
    chk("async_clr stall",   32'(q.Stall),   32'h0);
    chk("async_clr count",   32'(q.Count),   32'h0);
    chk("async_clr d_inst",  q.D_Inst,       32'h0);
    @(negedge clk);
    clr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
